// File: rtl/disp_seq_pkg.sv
// Shared display definitions: sequencer state encoding, error bit positions
// and resolution codes common to the sequencer and the sync generator.
package disp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SGRST = 2'd1,
    ST_WAITV = 2'd2,
    ST_RUN   = 2'd3
  } disp_state_t;

  localparam int ERR_UDF = 0;
  localparam int ERR_OVR = 1;

  localparam logic [1:0] RESOL_VGA  = 2'd0;
  localparam logic [1:0] RESOL_SVGA = 2'd1;
  localparam logic [1:0] RESOL_XGA  = 2'd2;
  localparam logic [1:0] RESOL_SXGA = 2'd3;

endpackage

// File: rtl/disp_frmreq.sv
// Frame-start REQ/ACK flag toward the VRAM reader, with overrun detection
// when a new frame is issued while the previous request is still pending.
module disp_frmreq (
  input  logic DCLK,
  input  logic DRST_X,
  input  logic issue,
  input  logic abandon,
  input  logic FRM_ACK,
  output logic FRM_REQ,
  output logic overrun
);

  // A new issue outranks an ACK in the same cycle so the next frame is never lost.
  always_ff @(posedge DCLK or negedge DRST_X) begin
    if (!DRST_X) begin
      FRM_REQ <= 1'b0;
    end else if (abandon) begin
      FRM_REQ <= 1'b0;
    end else if (issue) begin
      FRM_REQ <= 1'b1;
    end else if (FRM_ACK) begin
      FRM_REQ <= 1'b0;
    end
  end

  assign overrun = issue & FRM_REQ;

endmodule

// File: rtl/disp_seq.sv
// Display sequencer: brings the sync generator out of reset on DISPON,
// applies resolution changes at frame boundaries and issues frame requests.
module disp_seq
  import disp_seq_pkg::*;
#(
  parameter int RST_CYC = 16
) (
  input  logic        DCLK,
  input  logic        DRST_X,
  input  logic        DISPON,
  input  logic [1:0]  RESOL_REQ,
  input  logic        VRSTART,
  input  logic        DSP_preDE,
  input  logic        FIFO_EMPTY,
  input  logic        FRM_ACK,
  input  logic        ERR_CLR,
  output logic        SG_RST,
  output logic [1:0]  SG_RESOL,
  output logic        FRM_REQ,
  output logic        BUSY,
  output logic [1:0]  ERR,
  output logic [15:0] FRAME_CNT
);

  localparam logic [7:0] CNT_LOAD = 8'(RST_CYC - 1);

  disp_state_t state;
  logic [7:0]  cnt;
  logic        vr_d;
  logic        vr_rise;
  logic        resol_chg;
  logic        issue;
  logic        abandon;
  logic        overrun;
  logic [1:0]  err_set;

  assign vr_rise   = VRSTART & ~vr_d;
  assign resol_chg = (RESOL_REQ != SG_RESOL);

  // Frame boundary decisions shared by the FSM and the request flag.
  assign issue   = vr_rise & DISPON &
                   ((state == ST_WAITV) | ((state == ST_RUN) & ~resol_chg));
  assign abandon = vr_rise & (state == ST_RUN) & (~DISPON | resol_chg);

  always_comb begin
    err_set          = 2'b00;
    err_set[ERR_UDF] = (state == ST_RUN) & DSP_preDE & FIFO_EMPTY;
    err_set[ERR_OVR] = overrun;
  end

  always_ff @(posedge DCLK or negedge DRST_X) begin
    if (!DRST_X) begin
      state     <= ST_IDLE;
      SG_RST    <= 1'b1;
      SG_RESOL  <= 2'd0;
      BUSY      <= 1'b0;
      FRAME_CNT <= 16'd0;
      cnt       <= 8'd0;
      vr_d      <= 1'b0;
    end else begin
      vr_d <= VRSTART;
      if (issue) FRAME_CNT <= FRAME_CNT + 16'd1;
      case (state)
        ST_IDLE: begin
          SG_RST <= 1'b1;
          if (DISPON) begin
            SG_RESOL <= RESOL_REQ;
            cnt      <= CNT_LOAD;
            BUSY     <= 1'b1;
            state    <= ST_SGRST;
          end
        end
        ST_SGRST: begin
          if (!DISPON) begin
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end else if (cnt == 8'd0) begin
            SG_RST <= 1'b0;
            state  <= ST_WAITV;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_WAITV: begin
          if (!DISPON) begin
            SG_RST <= 1'b1;
            BUSY   <= 1'b0;
            state  <= ST_IDLE;
          end else if (vr_rise) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (vr_rise && !DISPON) begin
            SG_RST <= 1'b1;
            BUSY   <= 1'b0;
            state  <= ST_IDLE;
          end else if (vr_rise && resol_chg) begin
            SG_RST   <= 1'b1;
            SG_RESOL <= RESOL_REQ;
            cnt      <= CNT_LOAD;
            state    <= ST_SGRST;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A set in the same cycle as ERR_CLR keeps the bit high.
  always_ff @(posedge DCLK or negedge DRST_X) begin
    if (!DRST_X) begin
      ERR <= 2'b00;
    end else begin
      ERR <= (ERR & {2{~ERR_CLR}}) | err_set;
    end
  end

  disp_frmreq u_frmreq (
    .DCLK    (DCLK),
    .DRST_X  (DRST_X),
    .issue   (issue),
    .abandon (abandon),
    .FRM_ACK (FRM_ACK),
    .FRM_REQ (FRM_REQ),
    .overrun (overrun)
  );

endmodule

// File: doc/disp_seq.md
# disp_seq

Display sequencer sitting above the sync generator in the display IP. It owns the sync generator's reset and resolution inputs and brings it up cleanly on display enable. It applies resolution changes only at frame boundaries and issues one frame-start request per frame to the VRAM reader through a REQ/ACK handshake. It also flags pixel-FIFO underflow and frame-request overrun as sticky errors.

## Interface
- RST_CYC, 16, DCLK cycles the sync generator is held in reset on each (re)start; legal 2..255
- DCLK  in  1  display clock
- DRST_X  in  1  reset, asynchronous, active-low
- DISPON  in  1  display enable, already synchronous to DCLK
- RESOL_REQ  in  2  requested resolution code, already synchronous to DCLK
- VRSTART  in  1  from sync generator; high for one line before the active area
- DSP_preDE  in  1  from sync generator; pre-data-enable
- FIFO_EMPTY  in  1  pixel FIFO empty flag from the fetch path
- FRM_ACK  in  1  frame-start acknowledge from the VRAM reader
- ERR_CLR  in  1  one-cycle pulse, clears ERR
- SG_RST  out  1  active-high reset to the sync generator
- SG_RESOL  out  2  resolution code to the sync generator
- FRM_REQ  out  1  frame-start request
- BUSY  out  1  state != IDLE
- ERR  out  2  sticky errors: [0] underflow, [1] request overrun
- FRAME_CNT  out  16  frames started, wraps

## Operation
- Edge detect: vr_d is the registered VRSTART; vr_rise = VRSTART & ~vr_d.
- States:
  - IDLE
    - SG_RST=1.
    - When DISPON=1: load SG_RESOL<=RESOL_REQ, load cnt<=RST_CYC-1, go to SGRST.
  - SGRST
    - SG_RST=1; cnt decrements.
    - At cnt==0: SG_RST<=0, go to WAITV.
    - If DISPON=0: go to IDLE.
  - WAITV
    - Wait for the first vr_rise. On it: FRM_REQ<=1, FRAME_CNT+1, go to RUN.
    - If DISPON=0: go to IDLE.
  - RUN. Actions are evaluated only on vr_rise, first matching rule wins:
    1. DISPON=0: go to IDLE.
    2. RESOL_REQ != SG_RESOL: load SG_RESOL and cnt, go to SGRST.
    3. Otherwise: FRM_REQ<=1, FRAME_CNT+1.
- Handshake:
  - Once raised, FRM_REQ stays high until FRM_ACK is sampled high. It drops the following cycle.
  - FRM_ACK arriving in the same cycle FRM_REQ first goes high is legal.
  - FRM_ACK while FRM_REQ=0 is ignored.
- Overrun: vr_rise in RUN while FRM_REQ is still high sets ERR[1]. FRM_REQ stays high and serves as the new frame's request, so there is no second request. FRAME_CNT still increments.
- Leaving RUN (to IDLE or SGRST) forces FRM_REQ<=0 and abandons any pending handshake.
- Underflow: in RUN, DSP_preDE & FIFO_EMPTY sets ERR[0].
- ERR behaviour:
  - ERR_CLR clears both bits.
  - A set condition in the same cycle as ERR_CLR wins, so the bit stays 1.
  - ERR persists across IDLE.

## Timing
- Reset values: state=IDLE, SG_RST=1, SG_RESOL=0, FRM_REQ=0, BUSY=0, ERR=0, FRAME_CNT=0, vr_d=0.
- All outputs are registered.
- DISPON rising: SGRST is entered 1 cycle later. SG_RST is high for exactly RST_CYC cycles after IDLE is left, then falls.
- VRSTART high at cycle t (previous cycle low) gives vr_rise at t and FRM_REQ=1 at t+1.
- RESOL_REQ changes outside a vr_rise in RUN have no effect until the next frame boundary.
- SG_RESOL changes only in the same cycle SG_RST is, or becomes, 1.
- FRAME_CNT wraps 0xFFFF→0 silently.
- DRST_X low mid-operation returns everything to reset values immediately (asynchronously). Only DCLK edges after DRST_X deasserts count.

## Structure
- Shared display package holds:
  - state encoding (IDLE, SGRST, WAITV, RUN)
  - ERR bit indices
  - resolution code constants, also used by the sync generator's parameter include
- One natural sub-module: disp_frmreq, covering the REQ/ACK handshake flag plus overrun detection.
- The FSM, reset counter, and error/frame counters stay in disp_seq.

## Test plan
- Bring-up
  - Stimulus: reset, DISPON=1 at cycle 10, RST_CYC=16, RESOL_REQ=2.
  - Required: SG_RST high through cycle 26, low at 27; SG_RESOL=2; first vr_rise raises FRM_REQ next cycle; FRAME_CNT=1.
- Handshake
  - Stimulus: FRM_ACK delayed 5 cycles, then a second case with ACK in the same cycle REQ rises.
  - Required: FRM_REQ high exactly until the cycle after the ACK sample; no ERR.
- Overrun
  - Stimulus: FRM_ACK held low across two VRSTART rises.
  - Required: ERR[1]=1, FRM_REQ continuously high, FRAME_CNT +2; ERR_CLR then clears it.
- Resolution change
  - Stimulus: RESOL_REQ 0→1 mid-frame.
  - Required: no change until next vr_rise; then SG_RST high for RST_CYC cycles, SG_RESOL=1, FRM_REQ dropped.
- Disable and underflow
  - Stimulus: FIFO_EMPTY=1 with DSP_preDE=1 in RUN; later DISPON=0 mid-frame.
  - Required: ERR[0]=1; IDLE and SG_RST=1 only at next vr_rise.
- Async reset
  - Stimulus: DRST_X low mid-handshake.
  - Required: all outputs at reset values before the next DCLK edge.
